// File: rtl/cpu.sv
// cpu: minimal 16-bit LC-3-subset core driving an asynchronous 16-bit SRAM with registered strobes.
// Optional PAUSE instruction (opcode 1101) is enabled by defining CPU_PAUSE_EN.
module cpu (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic [19:0] ADDR,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  localparam int unsigned W = 16;

  localparam logic [3:0] S_HALTED    = 4'd0;
  localparam logic [3:0] S_FETCH1    = 4'd1;
  localparam logic [3:0] S_RD1       = 4'd2;
  localparam logic [3:0] S_RD2       = 4'd3;
  localparam logic [3:0] S_FETCH3    = 4'd4;
  localparam logic [3:0] S_DECODE    = 4'd5;
  localparam logic [3:0] S_EXEC      = 4'd6;
  localparam logic [3:0] S_MEM_RD1   = 4'd7;
  localparam logic [3:0] S_MEM_RD2   = 4'd8;
  localparam logic [3:0] S_LD_WB     = 4'd9;
  localparam logic [3:0] S_MEM_WR1   = 4'd10;
  localparam logic [3:0] S_MEM_WR2   = 4'd11;
  localparam logic [3:0] S_PAUSED    = 4'd12;
  localparam logic [3:0] S_PAUSE_REL = 4'd13;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;

  logic [3:0]   state, state_nxt;
  logic [W-1:0] pc, ir, mar, mdr;
  logic [W-1:0] regs [8];
  logic [2:0]   nzp;
  logic         ce_n, oe_n, we_n;
  logic         rd_nxt, wr_nxt;
  logic [3:0]   opcode;
  logic [2:0]   dr, sr1, sr2;
  logic [W-1:0] src2, alu_res, eff_addr, br_off;

  assign opcode   = ir[15:12];
  assign dr       = ir[11:9];
  assign sr1      = ir[8:6];
  assign sr2      = ir[2:0];
  assign eff_addr = regs[sr1] + {{10{ir[5]}}, ir[5:0]};
  assign br_off   = {{7{ir[8]}}, ir[8:0]};

  function automatic logic [2:0] cc_of(input logic [W-1:0] v);
    return {v[W-1], v == '0, !v[W-1] && (v != '0)};
  endfunction

  // ALU for ADD/AND/NOT
  always_comb begin
    src2    = ir[5] ? {{11{ir[4]}}, ir[4:0]} : regs[sr2];
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = regs[sr1] + src2;
      OP_AND:  alu_res = regs[sr1] & src2;
      OP_NOT:  alu_res = ~regs[sr1];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_HALTED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HALTED:    if (!Run) state_nxt = S_FETCH1;
      S_FETCH1:    state_nxt = S_RD1;
      S_RD1:       state_nxt = S_RD2;
      S_RD2:       state_nxt = S_FETCH3;
      S_FETCH3:    state_nxt = S_DECODE;
      S_DECODE: begin
`ifdef CPU_PAUSE_EN
        state_nxt = (opcode == 4'b1101) ? S_PAUSED : S_EXEC;
`else
        state_nxt = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (opcode == OP_LDR)      state_nxt = S_MEM_RD1;
        else if (opcode == OP_STR) state_nxt = S_MEM_WR1;
        else                       state_nxt = S_FETCH1;
      end
      S_MEM_RD1:   state_nxt = S_MEM_RD2;
      S_MEM_RD2:   state_nxt = S_LD_WB;
      S_LD_WB:     state_nxt = S_FETCH1;
      S_MEM_WR1:   state_nxt = S_MEM_WR2;
      S_MEM_WR2:   state_nxt = S_FETCH1;
      S_PAUSED:    if (!Continue) state_nxt = S_PAUSE_REL;
      S_PAUSE_REL: if (Continue)  state_nxt = S_FETCH1;
      default:     state_nxt = S_HALTED;
    endcase
  end

  // Strobes are registered from the upcoming state so they align with the access states
  assign rd_nxt = (state_nxt == S_RD1) || (state_nxt == S_RD2) ||
                  (state_nxt == S_MEM_RD1) || (state_nxt == S_MEM_RD2);
  assign wr_nxt = (state_nxt == S_MEM_WR1) || (state_nxt == S_MEM_WR2);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ce_n <= 1'b1;
      oe_n <= 1'b1;
      we_n <= 1'b1;
    end else begin
      ce_n <= !(rd_nxt || wr_nxt);
      oe_n <= !rd_nxt;
      we_n <= !wr_nxt;
    end
  end

  // Architectural state updates
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      nzp <= 3'b010;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH1: begin
          mar <= pc;
          pc  <= pc + W'(1);
        end
        S_RD2, S_MEM_RD2: mdr <= Data_in;
        S_FETCH3:         ir  <= mdr;
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT: begin
              regs[dr] <= alu_res;
              nzp      <= cc_of(alu_res);
            end
            OP_BR:  if ((dr & nzp) != 3'b000) pc <= pc + br_off;
            OP_JMP: pc <= regs[sr1];
            OP_LDR: mar <= eff_addr;
            OP_STR: begin
              mar <= eff_addr;
              mdr <= regs[dr];
            end
            default: ;
          endcase
        end
        S_LD_WB: begin
          regs[dr] <= mdr;
          nzp      <= cc_of(mdr);
        end
        default: ;
      endcase
    end
  end

  assign ADDR     = {4'h0, mar};
  assign Data_out = mdr;
  assign Mem_CE   = ce_n;
  assign Mem_UB   = ce_n;
  assign Mem_LB   = ce_n;
  assign Mem_OE   = oe_n;
  assign Mem_WE   = we_n;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: scoreboard bench for cpu; an ISA-level model predicts every SRAM access,
// a bus monitor observes the strobes and checks each access against the queue.
module tb_cpu;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Run = 1'b1;
  logic        Continue = 1'b1;
  logic [15:0] Data_in, Data_out;
  logic [19:0] ADDR;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  cpu dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Data_in(Data_in), .Data_out(Data_out), .ADDR(ADDR),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } xact_t;

  logic [15:0] mem [65536];
  logic [15:0] img [65536];
  logic [15:0] mm  [65536];
  logic        load_req = 1'b0;
  xact_t       exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          n_acc = 0;
  logic        mon_en = 1'b0;

  // SRAM model
  assign Data_in = (!Mem_CE && !Mem_OE) ? mem[ADDR[15:0]] : 16'hDEAD;
  always @(posedge Clk) begin
    if (load_req) for (int i = 0; i < 65536; i++) mem[i] <= img[i];
    else if (!Mem_CE && !Mem_WE) mem[ADDR[15:0]] <= Data_out;
  end

`ifdef CPU_PAUSE_EN
  always @(negedge Clk) if ($urandom_range(0, 5) == 0) Continue = ~Continue;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [2:0] flags(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  // ISA-level reference: runs n instructions from reset state, queuing every bus access
  task automatic model_run(input int n);
    logic [15:0] r [8];
    logic [15:0] pc, ir, a, b, v, ea;
    logic [2:0]  nzp;
    for (int i = 0; i < 8; i++) r[i] = 16'h0;
    pc = 16'h0;
    nzp = 3'b010;
    repeat (n) begin
      exp_q.push_back('{wr: 1'b0, addr: pc, data: 16'h0});
      ir = mm[pc];
      pc = pc + 16'd1;
      a  = r[ir[8:6]];
      ea = a + {{10{ir[5]}}, ir[5:0]};
      case (ir[15:12])
        4'b0001, 4'b0101, 4'b1001: begin
          b = ir[5] ? {{11{ir[4]}}, ir[4:0]} : r[ir[2:0]];
          if (ir[15:12] == 4'b0001)      v = a + b;
          else if (ir[15:12] == 4'b0101) v = a & b;
          else                           v = ~a;
          r[ir[11:9]] = v;
          nzp = flags(v);
        end
        4'b0000: if ((ir[11:9] & nzp) != 3'b000) pc = pc + {{7{ir[8]}}, ir[8:0]};
        4'b1100: pc = a;
        4'b0110: begin
          exp_q.push_back('{wr: 1'b0, addr: ea, data: 16'h0});
          r[ir[11:9]] = mm[ea];
          nzp = flags(mm[ea]);
        end
        4'b0111: begin
          exp_q.push_back('{wr: 1'b1, addr: ea, data: r[ir[11:9]]});
          mm[ea] = r[ir[11:9]];
        end
        default: ;
      endcase
    end
  endtask

  // Bus monitor
  logic        in_acc = 1'b0;
  logic        a_wr, proto_ok;
  logic [19:0] a0;
  logic [15:0] d0;
  int          acc_len;
  xact_t       e;
  always @(negedge Clk) begin
    if (!mon_en) in_acc = 1'b0;
    else if (!Mem_CE) begin
      if (!in_acc) begin
        in_acc = 1'b1; acc_len = 0; a0 = ADDR; a_wr = !Mem_WE; d0 = Data_out; proto_ok = 1'b1;
      end
      acc_len++;
      if (ADDR !== a0 || Mem_UB || Mem_LB || (Mem_WE !== !a_wr) || (Mem_OE !== a_wr) ||
          (a_wr && Data_out !== d0)) proto_ok = 1'b0;
    end else begin
      if (in_acc) begin
        if (exp_q.size() == 0) chk("unexpected access", 32'(a0), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("access kind", 32'(a_wr), 32'(e.wr));
          chk("access addr", 32'(a0), 32'({4'h0, e.addr}));
          if (e.wr) chk("write data", 32'(d0), 32'(e.data));
          chk("access length", 32'(acc_len), 32'd2);
          chk("access protocol", 32'(proto_ok), 32'd1);
        end
        in_acc = 1'b0;
        n_acc++;
      end
      chk("idle strobes", 32'({Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'hF);
    end
  end

  task automatic reload();
    Reset = 1'b0;
    Run = 1'b1;
    load_req = 1'b1;
    @(posedge Clk);
    #1 load_req = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic go(input int n);
    int base, target, cyc;
    for (int i = 0; i < 65536; i++) mm[i] = img[i];
    exp_q.delete();
    model_run(n);
    base = n_acc;
    target = base + exp_q.size();
    mon_en = 1'b1;
    @(negedge Clk); Run = 1'b0;
    @(negedge Clk); Run = 1'b1;
    cyc = 0;
    while (n_acc < target && cyc < n * 40 + 100) begin
      @(negedge Clk);
      cyc++;
      Run = ($urandom_range(0, 3) != 0);
    end
    Run = 1'b1;
    chk("accesses completed", 32'(n_acc - base), 32'(target - base));
    mon_en = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 65536; i++) img[i] = 16'h0;
  endtask

  task automatic gen_prog();
    logic [15:0] ins;
    logic [8:0]  off;
    int          k;
    clear_img();
    for (int i = 0; i < 256; i++) begin
      ins = 16'($urandom());
      k = $urandom_range(0, 15);
      case (k)
        0, 1, 2:    ins[15:12] = 4'b0001;
        3, 4:       ins[15:12] = 4'b0101;
        5:          ins[15:12] = 4'b1001;
        6, 7: begin
          ins[15:12] = 4'b0000;
          off = 9'($urandom_range(0, 16)) - 9'd8;
          ins[8:0] = off;
        end
        8:          ins[15:12] = ($urandom_range(0, 3) == 0) ? 4'b1100 : 4'b0001;
        9, 10:      ins[15:12] = 4'b0110;
        11, 12, 13: ins[15:12] = 4'b0111;
        14:         ins[15:12] = 4'b1101;
        default: begin
          case ($urandom_range(0, 3))
            0:       ins[15:12] = 4'b0010;
            1:       ins[15:12] = 4'b1010;
            2:       ins[15:12] = 4'b1110;
            default: ins[15:12] = 4'b1111;
          endcase
        end
      endcase
      img[i] = ins;
    end
  endtask

  initial begin
    int cnt;
    // Short reset, then the core must sit idle in HALTED
    #1 Reset = 1'b0;
    #2 Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("halted strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
      chk("halted addr", 32'(ADDR), 32'h0);
      chk("halted data_out", 32'(Data_out), 32'h0);
    end

    // ADD then STR
    clear_img();
    img[0] = 16'h1461;
    img[1] = 16'h7408;
    reload();
    go(2);

    // AND zero then BRz -1: must never fetch 0x0002
    clear_img();
    img[0] = 16'h5020;
    img[1] = 16'h05FF;
    reload();
    go(9);

    // Reset during the first fetch's read access
    clear_img();
    img[0] = 16'h1461;
    reload();
    @(negedge Clk); Run = 1'b0;
    @(negedge Clk); Run = 1'b1;
    cnt = 0;
    while (Mem_CE && cnt < 20) begin
      @(negedge Clk);
      cnt++;
    end
    chk("first fetch started", 32'(Mem_CE), 32'h0);
    #2 Reset = 1'b0;
    #1 chk("async reset strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
    @(posedge Clk);
    #1 Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("post-reset halted", 32'({Mem_CE, Mem_OE, Mem_WE}), 32'h7);
    end
    go(3);

    // Randomized programs
    for (int p = 0; p < 3; p++) begin
      gen_prog();
      reload();
      go(150);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
